clkdiv_nco: RTL and testbench
=============================

# clkdiv_nco

Multi-channel fractional clock-enable generator, successor to `clkdiv`. Each of `Channels` independent phase accumulators produces two outputs from the single system clock: an average-50%-duty `ckout` and a one-cycle `ckena` strobe, at a runtime-programmable rate of `From * incr / 2^Width`. Ratios are reprogrammed glitch-free through a valid/ready port. A common `sync` input re-phases all channels. It feeds peripheral timing such as UART baud, PWM and audio sample ticks.

## Interface

- `From`, 50000000: input clock frequency in Hz.
- `DownTo`, 1000000: reset-time output frequency for every channel. Elaboration error if `DownTo == 0` or `DownTo >= From`.
- `Channels`, 4: number of channels, 1..32.
- `Width`, 32: accumulator and increment width, 8..48.
- `clock`  in  1: single system clock, rising-edge.
- `reset`  in  1: synchronous, active-high.
- `cfg_valid`  in  1: configuration write request.
- `cfg_ready`  out  1: write accepted when `cfg_valid & cfg_ready`.
- `cfg_chan`  in  max(1,$clog2(Channels)): target channel. An out-of-range value is accepted and ignored.
- `cfg_incr`  in  Width: new increment.
- `cfg_enable`  in  1: new channel enable.
- `sync`  in  1: one-cycle re-phase request for all channels.
- `ckout`  out  Channels: per-channel divided clock level, registered.
- `ckena`  out  Channels: per-channel one-cycle strobe, registered.

## Operation

Per-channel state:
- `acc[Width]`, `incr[Width]`, `en`.
- `pend`, `pend_incr`: a deferred increment change.
- Output registers `ckout_q`, `ckena_q`.

Reset values: `acc = 0`, `incr = INCR0 = floor((DownTo << Width) / From)`, `en = 0`, `pend = 0`, `ckout = 0`, `ckena = 0`, `cfg_ready = 1`.

Per cycle, for an enabled channel:
- `{carry, acc_next} = acc + incr`.
- `ckena_q <= carry`.
- `ckout_q <= ~acc_next[Width-1]`.
- Result: the rising edge of `ckout` coincides with the `ckena` strobe.

Disabled channel: `acc` held at 0, `ckout = 0`, `ckena = 0`.

`incr == 0` on an enabled channel: `acc` frozen, no strobes, `ckout` constant.

`cfg_ready = ~pend[cfg_chan]` (combinational).

An accepted write takes one of these paths:
- Channel disabled, `cfg_enable = 1`:
  - `incr <= cfg_incr`, `acc <= 0`, `en <= 1` at the next edge.
  - The first accumulation happens the following cycle.
- `cfg_enable = 0`: immediate disable, `acc <= 0`, any pending change is dropped.
- Channel enabled, `cfg_enable = 1`:
  - `pend <= 1`, `pend_incr <= cfg_incr`.
  - On the next carry cycle, the wrap uses the old `incr`; `incr <= pend_incr` and `pend <= 0` on the same edge.

`sync` (on the same edge, for every enabled channel):
- `acc <= 0`.
- Pending increments are applied and cleared.
- `ckena_q <= 1`, `ckout_q <= 1` (phase-0 event).

Priority, highest first: `reset`, disable write, `sync`, pending-apply/enable write, accumulate. A write and `sync` in the same cycle: the write is applied as if pending, then `sync` clears `acc`.

## Timing

- Latency from write-accept (edge t) to a disabled channel running: `en = 1` after edge t. The first `ckena` comes after edge t + ceil(2^Width / incr).
- A deferred increment takes effect on the first wrap after acceptance; no shortened or runt `ckout` pulse is produced.
- Strobe spacing is `floor` or `ceil` of `2^Width / incr` cycles. Over 2^Width cycles from `acc = 0`, exactly `incr` strobes occur.
- Maximum rate is `incr = 2^Width - 1`: a strobe every cycle except one per 2^Width cycles. There is no exact full-rate mode.
- `reset` asserted mid-operation: all state takes reset values at that edge, and outputs are 0 from the following cycle.

## Structure

- Shared package `clkdiv_pkg` contains:
  - function `incr_of(from, downto, width)`, used for INCR0 and by the bench;
  - typedef `clkdiv_cfg_t` struct {chan, incr, enable};
  - elaboration checks as localparams.
- Sub-module `clkdiv_nco_chan` holds one channel's accumulator, pending logic and output registers. It is instantiated `Channels` times in a generate loop.
- The top level contains only handshake decode, channel select and `sync` fan-out.

## Test plan

All scenarios use `Width = 8`, `From = 256`.

- Reset check: hold `reset` 2 cycles -> `ckout = 0`, `ckena = 0`, `cfg_ready = 1`. Enable ch0 with `incr = 64` -> `ckena` every 4th cycle, `ckout` pattern 1,1,0,0.
- Fractional rate: ch1 `incr = 85`, run 256 cycles from enable -> exactly 85 strobes, each spaced 3 or 4 cycles.
- Deferred change: ch0 running at 64, write 128 mid-period -> `cfg_ready` low for ch0 until the next strobe, current period completes at 4 cycles, then period is 2. A second write while pending stalls.
- Sync: ch0 at 64, ch1 at 32, pulse `sync` -> both `ckena` assert on the next edge, then ch0 every 4 and ch1 every 8 cycles, aligned.
- Disable and zero increment: write `cfg_enable = 0` -> outputs 0 on the next cycle. `incr = 0` enabled -> no strobes for 1000 cycles.
- Reset mid-run: all channels active, assert `reset` for 1 cycle -> all outputs 0 and `incr = INCR0` for every channel. Enabling ch0 without a new ratio runs at `From * INCR0 / 2^Width`.

Source files
------------

// File: rtl/clkdiv_pkg.sv
// Shared definitions for the fractional clock-enable generator: rate helper,
// configuration payload and parameter legality check.
package clkdiv_pkg;

  localparam int unsigned MaxChannels = 32;
  localparam int unsigned MinWidth    = 8;
  localparam int unsigned MaxWidth    = 48;
  localparam int unsigned MaxChanW    = 5;

  typedef struct packed {
    logic [MaxChanW-1:0]  chan;
    logic [MaxWidth-1:0]  incr;
    logic                 enable;
  } clkdiv_cfg_t;

  // Increment giving an output of downto Hz from a from Hz clock.
  function automatic logic [63:0] incr_of(input longint unsigned from,
                                          input longint unsigned downto,
                                          input int unsigned     width);
    logic [127:0] num;
    num = 128'(downto) << width;
    return 64'(num / 128'(from));
  endfunction

  function automatic bit cfg_ok(input longint unsigned from,
                                input longint unsigned downto,
                                input int unsigned     channels,
                                input int unsigned     width);
    return (downto != 0) && (downto < from) &&
           (channels >= 1) && (channels <= MaxChannels) &&
           (width >= MinWidth) && (width <= MaxWidth);
  endfunction

endpackage

// File: rtl/clkdiv_nco_chan.sv
// One NCO channel: phase accumulator, deferred increment change and
// registered ckout/ckena outputs.
module clkdiv_nco_chan
  import clkdiv_pkg::*;
#(
  parameter int unsigned      Width = 32,
  parameter logic [Width-1:0] Incr0 = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr,
  input  logic             wr_enable,
  input  logic [Width-1:0] wr_incr,
  input  logic             sync,
  output logic             pend,
  output logic             ckout,
  output logic             ckena
);

  logic [Width-1:0] acc_q, acc_d;
  logic [Width-1:0] incr_q, incr_d;
  logic [Width-1:0] pend_incr_q, pend_incr_d;
  logic             en_q, en_d;
  logic             pend_q, pend_d;
  logic             ckout_q, ckout_d;
  logic             ckena_q, ckena_d;
  logic [Width:0]   sum_c;
  logic             run_c;

  // Priority: disable write, sync, enable write / pending apply, accumulate.
  always_comb begin
    acc_d       = acc_q;
    incr_d      = incr_q;
    pend_incr_d = pend_incr_q;
    en_d        = en_q;
    pend_d      = pend_q;
    ckout_d     = 1'b0;
    ckena_d     = 1'b0;
    sum_c       = {1'b0, acc_q} + {1'b0, incr_q};
    run_c       = en_q | (wr & wr_enable);

    if (wr && !wr_enable) begin
      en_d   = 1'b0;
      acc_d  = '0;
      pend_d = 1'b0;
    end else if (sync && run_c) begin
      en_d    = 1'b1;
      acc_d   = '0;
      pend_d  = 1'b0;
      ckena_d = 1'b1;
      ckout_d = 1'b1;
      if (wr) begin
        incr_d = wr_incr;
      end else if (pend_q) begin
        incr_d = pend_incr_q;
      end
    end else if (!en_q) begin
      acc_d = '0;
      if (wr) begin
        incr_d = wr_incr;
        en_d   = 1'b1;
      end
    end else begin
      acc_d   = sum_c[Width-1:0];
      ckena_d = sum_c[Width];
      ckout_d = ~sum_c[Width-1];
      // The wrap that retires a pending change still uses the old increment.
      if (wr) begin
        pend_d      = 1'b1;
        pend_incr_d = wr_incr;
      end else if (pend_q && sum_c[Width]) begin
        incr_d = pend_incr_q;
        pend_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q       <= '0;
      incr_q      <= Incr0;
      pend_incr_q <= '0;
      en_q        <= 1'b0;
      pend_q      <= 1'b0;
      ckout_q     <= 1'b0;
      ckena_q     <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      incr_q      <= incr_d;
      pend_incr_q <= pend_incr_d;
      en_q        <= en_d;
      pend_q      <= pend_d;
      ckout_q     <= ckout_d;
      ckena_q     <= ckena_d;
    end
  end

  assign pend  = pend_q;
  assign ckout = ckout_q;
  assign ckena = ckena_q;

endmodule

// File: rtl/clkdiv_nco.sv
// Multi-channel fractional clock-enable generator: configuration handshake
// decode, channel select and sync fan-out around per-channel NCOs.
module clkdiv_nco
  import clkdiv_pkg::*;
#(
  parameter int unsigned From     = 50000000,
  parameter int unsigned DownTo   = 1000000,
  parameter int unsigned Channels = 4,
  parameter int unsigned Width    = 32,
  localparam int unsigned ChanW   = (Channels > 1) ? $clog2(Channels) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [ChanW-1:0]    cfg_chan,
  input  logic [Width-1:0]    cfg_incr,
  input  logic                cfg_enable,
  input  logic                sync,
  output logic [Channels-1:0] ckout,
  output logic [Channels-1:0] ckena
);

  localparam bit               CfgOk    = cfg_ok(From, DownTo, Channels, Width);
  localparam logic [Width-1:0] Incr0    = Width'(incr_of(From, DownTo, Width));
  localparam int unsigned      NumSlots = 1 << ChanW;

  if (!CfgOk) begin : g_cfg_err
    $error("clkdiv_nco: illegal From/DownTo/Channels/Width");
  end

  logic [Channels-1:0] chan_pend;
  logic [NumSlots-1:0] pend_pad_c;
  logic                accept_c;

  // Unpopulated channel slots read as not pending, so writes to them are
  // accepted and dropped.
  assign pend_pad_c = NumSlots'(chan_pend);
  assign cfg_ready  = ~pend_pad_c[cfg_chan];
  assign accept_c   = cfg_valid & cfg_ready;

  for (genvar i = 0; i < Channels; i++) begin : g_chan
    logic wr_c;
    assign wr_c = accept_c && (cfg_chan == ChanW'(i));

    clkdiv_nco_chan #(
      .Width (Width),
      .Incr0 (Incr0)
    ) u_chan (
      .clock     (clock),
      .reset     (reset),
      .wr        (wr_c),
      .wr_enable (cfg_enable),
      .wr_incr   (cfg_incr),
      .sync      (sync),
      .pend      (chan_pend[i]),
      .ckout     (ckout[i]),
      .ckena     (ckena[i])
    );
  end

endmodule

// File: tb/tb_clkdiv_nco.sv
// Directed self-checking bench for clkdiv_nco with Width = 8, From = 256,
// DownTo = 16 (reset-time increment 16).
module tb_clkdiv_nco;
  import clkdiv_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_chan;
  logic [7:0] cfg_incr;
  logic       cfg_enable;
  logic       sync;
  logic [3:0] ckout;
  logic [3:0] ckena;

  int tests = 0;
  int fails = 0;

  clkdiv_nco #(
    .From     (256),
    .DownTo   (16),
    .Channels (4),
    .Width    (8)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_chan   (cfg_chan),
    .cfg_incr   (cfg_incr),
    .cfg_enable (cfg_enable),
    .sync       (sync),
    .ckout      (ckout),
    .ckena      (ckena)
  );

  always #5 clock = ~clock;

  // Drive one write at a falling edge; accepted on the following rising edge.
  task automatic do_write(input int ch, input int inc, input bit en);
    clkdiv_cfg_t c;
    c = '{chan: 5'(ch), incr: 48'(inc), enable: en};
    cfg_chan   = 2'(c.chan);
    cfg_incr   = 8'(c.incr);
    cfg_enable = c.enable;
    cfg_valid  = 1'b1;
    @(negedge clock);
    cfg_valid  = 1'b0;
  endtask

  task automatic disable_all();
    for (int i = 0; i < 4; i++) do_write(i, 0, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    tests++; if (ckout !== 4'h0) begin fails++; $display("FAIL reset_ckout got %h exp 0", ckout); end
    tests++; if (ckena !== 4'h0) begin fails++; $display("FAIL reset_ckena got %h exp 0", ckena); end
    tests++; if (cfg_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b exp 1", cfg_ready); end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_basic();
    logic exp_ena, exp_out;
    do_write(0, 64, 1'b1);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clock);
      exp_ena = (k % 4 == 0);
      exp_out = (k % 4 == 0) || (k % 4 == 1);
      tests++; if (ckena[0] !== exp_ena) begin fails++; $display("FAIL basic_ckena k=%0d got %b exp %b", k, ckena[0], exp_ena); end
      tests++; if (ckout[0] !== exp_out) begin fails++; $display("FAIL basic_ckout k=%0d got %b exp %b", k, ckout[0], exp_out); end
    end
  endtask

  task automatic test_fractional();
    int cnt = 0, last = 0, bad = 0;
    disable_all();
    do_write(1, 85, 1'b1);
    for (int k = 1; k <= 256; k++) begin
      @(negedge clock);
      if (ckena[1]) begin
        cnt++;
        if (last == 0 && k != 4) bad++;
        if (last != 0 && (k - last < 3 || k - last > 4)) bad++;
        last = k;
      end
    end
    tests++; if (cnt != 85) begin fails++; $display("FAIL frac_count got %0d exp 85", cnt); end
    tests++; if (bad != 0) begin fails++; $display("FAIL frac_spacing got %0d bad gaps exp 0", bad); end
    tests++; if (ckena[1] !== 1'b1) begin fails++; $display("FAIL frac_wrap256 got %b exp 1", ckena[1]); end
  endtask

  task automatic test_deferred();
    disable_all();
    do_write(0, 64, 1'b1);
    repeat (2) @(negedge clock);
    tests++; if (ckena[0] !== 1'b0) begin fails++; $display("FAIL defer_pre got %b exp 0", ckena[0]); end
    do_write(0, 128, 1'b1);
    tests++; if (cfg_ready !== 1'b0) begin fails++; $display("FAIL defer_ready_low got %b exp 0", cfg_ready); end
    tests++; if (ckena[0] !== 1'b0) begin fails++; $display("FAIL defer_no_early got %b exp 0", ckena[0]); end
    // Second write held while the first is pending.
    cfg_chan = 2'd0; cfg_incr = 8'd32; cfg_enable = 1'b1; cfg_valid = 1'b1;
    @(negedge clock);
    tests++; if (ckena[0] !== 1'b1) begin fails++; $display("FAIL defer_old_period got %b exp 1", ckena[0]); end
    tests++; if (cfg_ready !== 1'b1) begin fails++; $display("FAIL defer_ready_back got %b exp 1", cfg_ready); end
    @(negedge clock);
    cfg_valid = 1'b0;
    tests++; if (ckena[0] !== 1'b0) begin fails++; $display("FAIL defer_p2_mid got %b exp 0", ckena[0]); end
    tests++; if (cfg_ready !== 1'b0) begin fails++; $display("FAIL defer_stall_taken got %b exp 0", cfg_ready); end
    @(negedge clock);
    tests++; if (ckena[0] !== 1'b1) begin fails++; $display("FAIL defer_p2_end got %b exp 1", ckena[0]); end
    tests++; if (cfg_ready !== 1'b1) begin fails++; $display("FAIL defer_ready_final got %b exp 1", cfg_ready); end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      tests++; if (ckena[0] !== 1'(k == 8)) begin fails++; $display("FAIL defer_p8 k=%0d got %b exp %b", k, ckena[0], 1'(k == 8)); end
    end
  endtask

  task automatic test_sync();
    logic [1:0] exp_ena;
    disable_all();
    do_write(0, 64, 1'b1);
    do_write(1, 32, 1'b1);
    repeat (5) @(negedge clock);
    sync = 1'b1;
    @(negedge clock);
    sync = 1'b0;
    tests++; if (ckena[1:0] !== 2'b11) begin fails++; $display("FAIL sync_ckena got %b exp 11", ckena[1:0]); end
    tests++; if (ckout[1:0] !== 2'b11) begin fails++; $display("FAIL sync_ckout got %b exp 11", ckout[1:0]); end
    for (int k = 1; k <= 16; k++) begin
      @(negedge clock);
      exp_ena = {1'(k % 8 == 0), 1'(k % 4 == 0)};
      tests++; if (ckena[1:0] !== exp_ena) begin fails++; $display("FAIL sync_align k=%0d got %b exp %b", k, ckena[1:0], exp_ena); end
      tests++; if (ckout[1] !== 1'(k % 8 < 4)) begin fails++; $display("FAIL sync_ckout1 k=%0d got %b exp %b", k, ckout[1], 1'(k % 8 < 4)); end
    end
  endtask

  task automatic test_disable_zero();
    int bad_off = 0, bad_ena = 0, bad_out = 0;
    do_write(0, 0, 1'b0);
    tests++; if (ckout[0] !== 1'b0 || ckena[0] !== 1'b0) begin fails++; $display("FAIL dis_now got %b%b exp 00", ckout[0], ckena[0]); end
    repeat (8) begin
      @(negedge clock);
      if (ckout[0] !== 1'b0 || ckena[0] !== 1'b0) bad_off++;
    end
    tests++; if (bad_off != 0) begin fails++; $display("FAIL dis_hold got %0d active cycles exp 0", bad_off); end
    do_write(2, 0, 1'b1);
    repeat (1000) begin
      @(negedge clock);
      if (ckena[2] !== 1'b0) bad_ena++;
      if (ckout[2] !== 1'b1) bad_out++;
    end
    tests++; if (bad_ena != 0) begin fails++; $display("FAIL zero_strobes got %0d exp 0", bad_ena); end
    tests++; if (bad_out != 0) begin fails++; $display("FAIL zero_ckout_const got %0d changes exp 0", bad_out); end
  endtask

  task automatic test_reset_mid();
    do_write(0, 64, 1'b1);
    do_write(1, 85, 1'b1);
    do_write(2, 32, 1'b1);
    do_write(3, 200, 1'b1);
    repeat (10) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    tests++; if (ckout !== 4'h0) begin fails++; $display("FAIL rmid_ckout got %h exp 0", ckout); end
    tests++; if (ckena !== 4'h0) begin fails++; $display("FAIL rmid_ckena got %h exp 0", ckena); end
    for (int i = 0; i < 4; i++) begin
      cfg_chan = 2'(i);
      #1;
      tests++; if (cfg_ready !== 1'b1) begin fails++; $display("FAIL rmid_ready ch%0d got %b exp 1", i, cfg_ready); end
    end
    tests++; if (dut.g_chan[0].u_chan.incr_q !== 8'd16) begin fails++; $display("FAIL rmid_incr0 got %0d exp 16", dut.g_chan[0].u_chan.incr_q); end
    tests++; if (dut.g_chan[1].u_chan.incr_q !== 8'd16) begin fails++; $display("FAIL rmid_incr1 got %0d exp 16", dut.g_chan[1].u_chan.incr_q); end
    tests++; if (dut.g_chan[2].u_chan.incr_q !== 8'd16) begin fails++; $display("FAIL rmid_incr2 got %0d exp 16", dut.g_chan[2].u_chan.incr_q); end
    tests++; if (dut.g_chan[3].u_chan.incr_q !== 8'd16) begin fails++; $display("FAIL rmid_incr3 got %0d exp 16", dut.g_chan[3].u_chan.incr_q); end
    @(negedge clock);
    do_write(0, 16, 1'b1);
    for (int k = 1; k <= 32; k++) begin
      @(negedge clock);
      tests++; if (ckena[0] !== 1'(k % 16 == 0)) begin fails++; $display("FAIL rmid_rate k=%0d got %b exp %b", k, ckena[0], 1'(k % 16 == 0)); end
    end
  endtask

  initial begin
    reset      = 1'b1;
    cfg_valid  = 1'b0;
    cfg_chan   = 2'd0;
    cfg_incr   = 8'd0;
    cfg_enable = 1'b0;
    sync       = 1'b0;
    @(negedge clock);
    test_reset();
    test_basic();
    test_fractional();
    test_deferred();
    test_sync();
    test_disable_zero();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
